// File: rtl/intc_vec.sv
`default_nettype none
// ============================================================================
// Module      : intc_vec
// Description : Vectored interrupt controller. It synchronises NCH interrupt
//               lines and handles level or edge triggering for each channel.
//               It arbitrates by priority against a threshold and presents one
//               ID to the core through a valid/ready handshake, holding it in
//               service until software writes EOI.
// Revision    : 1.0 - initial release
// ============================================================================
module intc_vec #(
    parameter int DW  = 16,
    parameter int AW  = 13,
    parameter int NCH = 16,
    parameter int PW  = 2,
    parameter int CW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic [DW-1:0] dout,
    input  logic [NCH-1:0] intp_i,
    output logic          int_vld,
    output logic [CW-1:0] int_id,
    input  logic          int_rdy
);

    localparam logic [AW-1:0] c_addr_ctrl = AW'(0);
    localparam logic [AW-1:0] c_addr_pend = AW'(1);
    localparam logic [AW-1:0] c_addr_eoi  = AW'(2);
    localparam logic [AW-1:0] c_addr_cfg  = AW'(16);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_serv = 2'd2;

    logic [NCH-1:0] r_s1, r_s2, r_s3;
    logic [NCH-1:0] r_en;
    logic [1:0]     r_trig [NCH];
    logic [PW-1:0]  r_prio [NCH];
    logic [NCH-1:0] r_pend_edge;
    logic           r_gie;
    logic [PW-1:0]  r_thr;
    logic [CW-1:0]  r_act_id;
    logic [1:0]     r_state;
    logic           r_int_vld;
    logic [CW-1:0]  r_int_id;
    logic [DW-1:0]  r_dout;

    logic           w_wr_ctrl, w_wr_pend, w_wr_eoi, w_accept;
    logic [NCH-1:0] w_set, w_clr, w_pending, w_elig;
    logic           w_any;
    logic [CW-1:0]  w_win_id;
    logic [PW-1:0]  w_win_prio;
    logic [DW-1:0]  w_rdata;

    // Bus write strobes and the handshake acceptance condition
    always_comb begin
        w_wr_ctrl = we && (addr == c_addr_ctrl);
        w_wr_pend = we && (addr == c_addr_pend);
        w_wr_eoi  = we && (addr == c_addr_eoi);
        w_accept  = (r_state == c_st_req) && r_int_vld && int_rdy;
    end

    // Per-channel edge detect, pending view, clear conditions and eligibility
    always_comb begin
        w_set     = '0;
        w_clr     = '0;
        w_pending = '0;
        w_elig    = '0;
        for (int n = 0; n < NCH; n++) begin
            // TRIG[0] selects falling over rising in edge modes
            w_set[n] = r_en[n] && r_trig[n][1] &&
                       (r_trig[n][0] ? (!r_s2[n] && r_s3[n]) : (r_s2[n] && !r_s3[n]));
            w_clr[n] = !r_en[n] || (w_wr_pend && din[n]) ||
                       (w_accept && (r_int_id == CW'(n)));
            // Level modes follow s2 directly; TRIG[0]=1 selects active-low
            w_pending[n] = r_trig[n][1] ? r_pend_edge[n]
                                        : (r_en[n] && (r_s2[n] ^ r_trig[n][0]));
            w_elig[n] = w_pending[n] && (r_prio[n] > r_thr);
        end
    end

    // Highest priority wins; strict compare keeps the lowest index on ties
    always_comb begin
        w_any      = 1'b0;
        w_win_id   = '0;
        w_win_prio = '0;
        for (int n = 0; n < NCH; n++) begin
            if (w_elig[n] && (!w_any || (r_prio[n] > w_win_prio))) begin
                w_any      = 1'b1;
                w_win_id   = CW'(n);
                w_win_prio = r_prio[n];
            end
        end
    end

    // Read data multiplexer; unmapped addresses and EOI read as zero
    always_comb begin
        w_rdata = '0;
        if (addr == c_addr_ctrl) begin
            w_rdata[0]       = r_gie;
            w_rdata[1]       = (r_state != c_st_idle);
            w_rdata[4 +: PW] = r_thr;
            w_rdata[8 +: CW] = r_act_id;
        end else if (addr == c_addr_pend) begin
            w_rdata[NCH-1:0] = w_pending;
        end
        for (int n = 0; n < NCH; n++) begin
            if (addr == (c_addr_cfg + AW'(n))) begin
                w_rdata[0]       = r_en[n];
                w_rdata[2:1]     = r_trig[n];
                w_rdata[4 +: PW] = r_prio[n];
            end
        end
    end

    // Three-flop synchroniser chain; s3 only serves edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= intp_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edge pending latch; a new edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_edge <= '0;
        end else begin
            r_pend_edge <= w_set | (r_pend_edge & ~w_clr);
        end
    end

    // Control and per-channel configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gie <= 1'b0;
            r_thr <= '0;
            r_en  <= '0;
            for (int n = 0; n < NCH; n++) begin
                r_trig[n] <= '0;
                r_prio[n] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_gie <= din[0];
                r_thr <= din[4 +: PW];
            end
            for (int n = 0; n < NCH; n++) begin
                if (we && (addr == (c_addr_cfg + AW'(n)))) begin
                    r_en[n]   <= din[0];
                    r_trig[n] <= din[2:1];
                    r_prio[n] <= din[4 +: PW];
                end
            end
        end
    end

    // Registered read port; holds during writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (!we) begin
            r_dout <= w_rdata;
        end
    end

    // Request/service sequencer with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_int_vld <= 1'b0;
            r_int_id  <= '0;
            r_act_id  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_gie && w_any) begin
                        r_int_vld <= 1'b1;
                        r_int_id  <= w_win_id;
                        r_state   <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (w_accept) begin
                        r_act_id  <= r_int_id;
                        r_int_vld <= 1'b0;
                        r_state   <= c_st_serv;
                    end else if (w_wr_ctrl && !din[0]) begin
                        r_int_vld <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                c_st_serv: begin
                    if (w_wr_eoi) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_int_vld <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign dout    = r_dout;
    assign int_vld = r_int_vld;
    assign int_id  = r_int_id;

endmodule
`default_nettype wire
